tdm_demux8: RTL and testbench

Time-division demultiplexer: the receive end of the 8:1 MUX link. It takes the single-bit stream a MUX8 produces when its select is swept slot 0..7 and rebuilds the 8-bit parallel word. It is frame-aligned by a slot-0 marker, tracks the current slot with an internal counter, and publishes a complete word with a one-cycle valid strobe. It sits directly downstream of the MUX8 output wire, in the same clock domain.

---
 rtl/tdm_pkg.sv | 12 +
 rtl/tdm_slot_counter.sv | 31 +++
 rtl/tdm_demux8.sv | 100 ++++++++++
 tb/tb_tdm_demux8.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// Shared constants and state encoding for the TDM demultiplexer.
package tdm_pkg;

    localparam int unsigned TDM_N  = 8;
    localparam int unsigned TDM_SW = 3;

    typedef enum logic {
        TDM_HUNT = 1'b0,
        TDM_RECV = 1'b1
    } tdm_state_e;

endpackage

// File: rtl/tdm_slot_counter.sv
// Wrapping slot counter: clear has priority over load1, load1 over inc.
module tdm_slot_counter
    import tdm_pkg::*;
#(
    parameter int unsigned SW = TDM_SW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          load1,
    input  logic          inc,
    output logic [SW-1:0] count
);

    logic [SW-1:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (clear) begin
            count_q <= '0;
        end else if (load1) begin
            count_q <= SW'(1);
        end else if (inc) begin
            count_q <= count_q + SW'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/tdm_demux8.sv
// Receive end of the 8:1 TDM link: frame-aligns on the slot-0 marker and
// publishes each completed 8-bit word with a one-cycle strobe.
module tdm_demux8
    import tdm_pkg::*;
#(
    parameter int unsigned N  = TDM_N,
    parameter int unsigned SW = TDM_SW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din,
    input  logic          din_valid,
    input  logic          frame_start,
    output logic [N-1:0]  out,
    output logic          frame_valid,
    output logic [SW-1:0] slot,
    output logic          sync_err
);

    tdm_state_e   state_q, state_d;
    logic [N-2:0] shd_q, shd_d;
    logic [N-1:0] out_q, out_d;
    logic         fv_q, fv_d;
    logic         se_q, se_d;
    logic         cnt_clear, cnt_load1, cnt_inc;

    tdm_slot_counter #(
        .SW (SW)
    ) u_slot_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (cnt_clear),
        .load1 (cnt_load1),
        .inc   (cnt_inc),
        .count (slot)
    );

    always_comb begin
        state_d   = state_q;
        shd_d     = shd_q;
        out_d     = out_q;
        fv_d      = 1'b0;
        se_d      = 1'b0;
        cnt_clear = 1'b0;
        cnt_load1 = 1'b0;
        cnt_inc   = 1'b0;
        if (din_valid) begin
            unique case (state_q)
                TDM_HUNT: begin
                    if (frame_start) begin
                        shd_d[0]  = din;
                        cnt_load1 = 1'b1;
                        state_d   = TDM_RECV;
                    end
                end
                TDM_RECV: begin
                    if (frame_start) begin
                        // A marker anywhere but slot 0 restarts the frame on this bit.
                        se_d      = (slot != '0);
                        shd_d[0]  = din;
                        cnt_load1 = 1'b1;
                    end else if (slot == '0) begin
                        se_d      = 1'b1;
                        cnt_clear = 1'b1;
                        state_d   = TDM_HUNT;
                    end else if (slot == SW'(N - 1)) begin
                        out_d   = {din, shd_q};
                        fv_d    = 1'b1;
                        cnt_inc = 1'b1;
                    end else begin
                        shd_d[slot] = din;
                        cnt_inc     = 1'b1;
                    end
                end
                default: state_d = TDM_HUNT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= TDM_HUNT;
            shd_q   <= '0;
            out_q   <= '0;
            fv_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            shd_q   <= shd_d;
            out_q   <= out_d;
            fv_q    <= fv_d;
            se_q    <= se_d;
        end
    end

    assign out         = out_q;
    assign frame_valid = fv_q;
    assign sync_err    = se_q;

endmodule

// File: tb/tb_tdm_demux8.sv
// Directed bench for tdm_demux8: a queue-based frame model checked every cycle,
// plus hand-computed literal expectations.
module tb_tdm_demux8;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       din_valid;
    logic       frame_start;
    logic [7:0] out;
    logic       frame_valid;
    logic [2:0] slot;
    logic       sync_err;

    int tests;
    int fails;
    int fv_seen;
    int se_seen;

    // Model: bits collected since the last marker, and whether we are locked.
    bit         q[$];
    bit         m_locked;
    logic [7:0] m_out;
    bit         m_fv;
    bit         m_se;
    int         m_slot;

    tdm_demux8 dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .din         (din),
        .din_valid   (din_valid),
        .frame_start (frame_start),
        .out         (out),
        .frame_valid (frame_valid),
        .slot        (slot),
        .sync_err    (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_locked = 1'b0;
        m_out    = 8'h00;
        m_fv     = 1'b0;
        m_se     = 1'b0;
        m_slot   = 0;
    endtask

    // Apply one beat, then advance the model to what must be visible after the edge.
    task automatic step(input bit v, input bit fs, input bit d);
        din_valid   = v;
        frame_start = fs;
        din         = d;
        @(posedge clk);
        #1;
        m_fv = 1'b0;
        m_se = 1'b0;
        if (v) begin
            if (fs) begin
                if (m_locked && q.size() > 0) m_se = 1'b1;
                q.delete();
                q.push_back(d);
                m_locked = 1'b1;
            end else if (m_locked) begin
                if (q.size() == 0) begin
                    m_se     = 1'b1;
                    m_locked = 1'b0;
                end else begin
                    q.push_back(d);
                    if (q.size() == 8) begin
                        for (int i = 0; i < 8; i++) m_out[i] = q[i];
                        m_fv = 1'b1;
                        q.delete();
                    end
                end
            end
        end
        m_slot = q.size();
    endtask

    task automatic send_frame(input logic [7:0] w);
        for (int k = 0; k < 8; k++) step(1'b1, k == 0, w[k]);
    endtask

    always @(negedge clk) begin
        chk("out", {24'h0, out}, {24'h0, m_out});
        chk("frame_valid", {31'h0, frame_valid}, {31'h0, m_fv});
        chk("sync_err", {31'h0, sync_err}, {31'h0, m_se});
        chk("slot", {29'h0, slot}, m_slot[31:0] & 32'h7);
        if (frame_valid === 1'b1 && sync_err === 1'b1) chk("exclusive", 32'd1, 32'd0);
        if (frame_valid === 1'b1) fv_seen++;
        if (sync_err === 1'b1) se_seen++;
    end

    initial begin
        int fv0;
        int se0;
        tests       = 0;
        fails       = 0;
        fv_seen     = 0;
        se_seen     = 0;
        rst_n       = 1'b0;
        din         = 1'b0;
        din_valid   = 1'b0;
        frame_start = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Single frame 8'h02.
        send_frame(8'h02);
        chk("single_out", {24'h0, out}, 32'h02);
        chk("single_fv", {31'h0, frame_valid}, 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("single_fv_drop", {31'h0, frame_valid}, 32'd0);

        // Reset with din_valid toggling, mid-frame, checked before any edge.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        din_valid = 1'b1;
        #1 din_valid = 1'b0;
        #1 din_valid = 1'b1;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst_out", {24'h0, out}, 32'h00);
        chk("rst_slot", {29'h0, slot}, 32'd0);
        chk("rst_fv", {31'h0, frame_valid}, 32'd0);
        chk("rst_se", {31'h0, sync_err}, 32'd0);
        din_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b1;

        // Back-to-back frames.
        fv0 = fv_seen;
        se0 = se_seen;
        send_frame(8'hA0);
        chk("b2b_first", {24'h0, out}, 32'hA0);
        send_frame(8'h0C);
        chk("b2b_second", {24'h0, out}, 32'h0C);
        step(1'b0, 1'b0, 1'b0);
        chk("b2b_fv_count", fv_seen - fv0, 32'd2);
        chk("b2b_se_count", se_seen - se0, 32'd0);

        // Gaps: 8'hC8 = bits 3,6,7.
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        repeat (3) begin
            step(1'b0, 1'b0, 1'b1);
            chk("gap1_slot", {29'h0, slot}, 32'd3);
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("gap2_slot", {29'h0, slot}, 32'd6);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("gap_out", {24'h0, out}, 32'hC8);

        // Early marker at slot 3, restarted frame 8'h07.
        send_frame(8'h80);
        se0 = se_seen;
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        chk("early_se", {31'h0, sync_err}, 32'd1);
        chk("early_out_kept", {24'h0, out}, 32'h80);
        chk("early_slot", {29'h0, slot}, 32'd1);
        for (int k = 1; k < 8; k++) step(1'b1, 1'b0, (k < 3));
        chk("early_restart_out", {24'h0, out}, 32'h07);
        chk("early_se_count", se_seen - se0, 32'd1);

        // Missing marker at slot 0, then unmarked bits ignored.
        step(1'b1, 1'b0, 1'b1);
        chk("miss_se", {31'h0, sync_err}, 32'd1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        chk("miss_ignored_slot", {29'h0, slot}, 32'd0);
        chk("miss_ignored_se", {31'h0, sync_err}, 32'd0);
        chk("miss_out_kept", {24'h0, out}, 32'h07);

        // Reset after slot 4 of 8'hA1, then a fresh 8'hA1.
        for (int k = 0; k < 5; k++) step(1'b1, k == 0, (8'hA1 >> k) & 1);
        din_valid = 1'b0;
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_out", {24'h0, out}, 32'h00);
        chk("midrst_slot", {29'h0, slot}, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        send_frame(8'hA1);
        chk("midrst_fresh_out", {24'h0, out}, 32'hA1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
